i2c_config_seq: RTL and testbench
=================================

Name: i2c_config_seq

Overview:
- Sequencer that configures the audio codec over I2C at power-up or on demand.
- Walks a fixed internal table of 16-bit register words and presents each as a 24-bit frame {DEV_ADDR, word} to the existing 24-bit I2C write engine.
- Drives the engine's start level, waits for end-of-transfer, checks the combined ACK-error flag, retries failed writes and reports done or error.
- Runs in the I2C clock domain, between top-level control and the I2C write engine.

Parameters:
- DEV_ADDR, 8'h34, codec 7-bit address plus R/W=0.
- NUM_REGS, 11, table entries used; range 1..16.
- MAX_RETRY, 3, extra attempts per entry after the first NACK.
- GAP_CYCLES, 2, idle cycles with start low between frames; minimum 2.
- TIMEOUT, 64, XFER cycles allowed before tr_end is treated as missing.
- AUTO_START, 1, if 1, a sequence launches on the first cycle after reset.

Ports:
- clock_i2c  in  1  I2C bit clock (10 kHz); sole clock.
- rst  in  1  synchronous, active-high reset.
- go  in  1  level/pulse; sampled in IDLE, DONE and FAIL to (re)start the sequence.
- i2c_start  out  1  start level to the write engine; high holds a transfer active.
- i2c_data  out  24  frame to the write engine, MSB first.
- tr_end  in  1  transfer-complete flag from the write engine.
- ack  in  1  OR of the three ACK samples from the write engine; 1 = NACK/error.
- busy  out  1  sequence in progress.
- done  out  1  all entries written successfully; sticky until the next start.
- error  out  1  an entry exhausted its retries; sticky until the next start.
- reg_index  out  4  current or failing table index.

Behaviour:
- Reset: i2c_start=0, i2c_data=0, busy=0, done=0, error=0, reg_index=0, retry=0, gap/timeout counters=0.
- After reset, the block enters IDLE, or LOAD if AUTO_START=1.
- Table, index 0..10:
  - 0: 0x1E00
  - 1: 0x0017
  - 2: 0x0217
  - 3: 0x0479
  - 4: 0x0679
  - 5: 0x0812
  - 6: 0x0A06
  - 7: 0x0C00
  - 8: 0x0E01
  - 9: 0x1002
  - 10: 0x1201
- Indices >= NUM_REGS are never accessed.
- State machine, all registered:
  - IDLE: i2c_start=0, busy=0. go=1 -> LOAD, with reg_index=0, retry=0, done=0, error=0.
  - LOAD (1 cycle): i2c_data <= {DEV_ADDR, table[reg_index]}; i2c_start=0; busy=1 -> XFER.
  - XFER: i2c_start=1; timeout counter increments each cycle. tr_end=1 -> CHECK. Counter reaching TIMEOUT-1 without tr_end -> CHECK, forced NACK.
  - CHECK (1 cycle): i2c_start <= 0.
    - ack=0 and reg_index=NUM_REGS-1 -> DONE.
    - ack=0 otherwise -> reg_index++, retry=0, GAP.
    - ack=1 (or timeout) and retry<MAX_RETRY -> retry++, same index, GAP.
    - otherwise -> FAIL.
  - GAP: i2c_start=0 for GAP_CYCLES cycles -> LOAD. This guarantees tr_end has cleared before the next XFER.
  - DONE: done=1, busy=0. go=1 -> restart as from IDLE.
  - FAIL: error=1, busy=0, reg_index holds the failing entry. go=1 -> restart.
- Sampling rules:
  - ack is sampled only in the cycle tr_end is first seen high.
  - A stale tr_end=1 in the first XFER cycle cannot occur, because of the LOAD plus GAP spacing.
- go during busy=1 is ignored.
- i2c_data is stable from LOAD through the end of CHECK.
- done and error are never high together.
- rst at any point, including mid-XFER, returns to reset values in the next cycle. i2c_start dropping aborts the engine's frame. With AUTO_START=1 the sequence restarts from index 0.
- Per-entry attempts: at most MAX_RETRY+1. Worst case a successful run takes NUM_REGS*(1+~34+1+GAP_CYCLES) cycles.

Test Plan:
- Nominal: AUTO_START=1, engine model always ACKs (tr_end 33 cycles after start, ack=0). Expect 11 frames 0x341E00 ... 0x341201 in order, i2c_start low >= 3 cycles between frames, done=1, busy=0, error=0.
- Single NACK: ack=1 on the first attempt of index 3 only. Expect 0x340479 sent twice, then the sequence completes with done=1 and 12 frames total.
- Persistent NACK: ack=1 on all attempts at index 5. Expect exactly 4 frames of 0x340812, error=1, reg_index=5, done=0, no further i2c_start.
- Timeout: engine never raises tr_end at index 0. Expect i2c_start to drop after 64 XFER cycles, 4 attempts, then error=1, reg_index=0.
- Reset mid-transfer: assert rst during the frame at index 7 (cycle 20 of XFER). Expect all outputs at reset values next cycle, then a restart at index 0 with frame 0x341E00.
- go handling: pulse go while busy. Expect no effect. After done, pulse go. Expect done cleared and a full 11-frame rerun.

Source files
------------

// File: rtl/i2c_config_seq.sv
// i2c_config_seq: walks a fixed table of codec register words and hands
// each one, prefixed with the codec device address, to the 24-bit I2C
// write engine. Failed or timed-out writes are retried a bounded number
// of times; the outcome is reported as sticky done or error flags.
module i2c_config_seq #(
  parameter logic [7:0] DEV_ADDR   = 8'h34,
  parameter int         NUM_REGS   = 11,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 2,
  parameter int         TIMEOUT    = 64,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic        clock_i2c,
  input  logic        rst,
  input  logic        go,
  output logic        i2c_start,
  output logic [23:0] i2c_data,
  input  logic        tr_end,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  reg_index
);

  // Counter widths sized so each terminal value fits.
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

  localparam logic [3:0]         LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_e;

  state_e state_q, state_d;

  logic               start_q,  start_d;
  logic [23:0]        data_q,   data_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               error_q,  error_d;
  logic [3:0]         index_q,  index_d;
  logic [RETRY_W-1:0] retry_q,  retry_d;
  logic [TO_W-1:0]    toCnt_q,  toCnt_d;
  logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
  logic               nack_q,   nack_d;

  // Codec register words in write order; unused slots read as zero.
  function automatic logic [15:0] regWord(input logic [3:0] idx);
    logic [15:0] word;
    case (idx)
      4'd0:    word = 16'h1E00;
      4'd1:    word = 16'h0017;
      4'd2:    word = 16'h0217;
      4'd3:    word = 16'h0479;
      4'd4:    word = 16'h0679;
      4'd5:    word = 16'h0812;
      4'd6:    word = 16'h0A06;
      4'd7:    word = 16'h0C00;
      4'd8:    word = 16'h0E01;
      4'd9:    word = 16'h1002;
      4'd10:   word = 16'h1201;
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

  // State register; reset lands in LOAD directly when auto-start is on.
  always_ff @(posedge clock_i2c) begin
    if (rst) begin
      state_q <= AUTO_START ? S_LOAD : S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision for the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (go) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_XFER;
      end
      S_XFER: begin
        if (tr_end || (toCnt_q == TO_LAST)) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!nack_q) begin
          state_d = (index_q == LAST_IDX) ? S_DONE : S_GAP;
        end else if (retry_q < RETRY_MAX) begin
          state_d = S_GAP;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values for outputs, table index, retry and cycle counters.
  always_comb begin
    data_d   = data_q;
    index_d  = index_q;
    retry_d  = retry_q;
    toCnt_d  = toCnt_q;
    gapCnt_d = gapCnt_q;
    nack_d   = nack_q;

    start_d = (state_d == S_XFER);
    busy_d  = (state_d == S_LOAD) || (state_d == S_XFER) ||
              (state_d == S_CHECK) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_FAIL);

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (go) begin
          index_d = 4'd0;
          retry_d = '0;
        end
      end
      S_LOAD: begin
        data_d  = {DEV_ADDR, regWord(index_q)};
        toCnt_d = '0;
        nack_d  = 1'b0;
      end
      S_XFER: begin
        if (tr_end) begin
          nack_d  = ack;
          toCnt_d = '0;
        end else if (toCnt_q == TO_LAST) begin
          nack_d  = 1'b1;
          toCnt_d = '0;
        end else begin
          toCnt_d = toCnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        gapCnt_d = '0;
        if (!nack_q) begin
          if (index_q != LAST_IDX) begin
            index_d = index_q + 4'd1;
            retry_d = '0;
          end
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          gapCnt_d = '0;
        end else begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end
      default: begin
        nack_d = nack_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock_i2c) begin
    if (rst) begin
      start_q  <= 1'b0;
      data_q   <= 24'h000000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      index_q  <= 4'd0;
      retry_q  <= '0;
      toCnt_q  <= '0;
      gapCnt_q <= '0;
      nack_q   <= 1'b0;
    end else begin
      start_q  <= start_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      index_q  <= index_d;
      retry_q  <= retry_d;
      toCnt_q  <= toCnt_d;
      gapCnt_q <= gapCnt_d;
      nack_q   <= nack_d;
    end
  end

  assign i2c_start = start_q;
  assign i2c_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign reg_index = index_q;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Testbench for i2c_config_seq: a behavioural write engine answers each
// frame from a scoreboard of expected frames and scripted responses.
module tb_i2c_config_seq;

  logic        clock_i2c;
  logic        rst;
  logic        go;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        tr_end;
  logic        ack;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  reg_index;

  typedef struct {
    logic [23:0] data;
    bit          nack;
    bit          noEnd;
  } frameT;

  frameT sbQ[$];
  frameT cur;

  logic [15:0] regTable [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479,
                                   16'h0679, 16'h0812, 16'h0A06, 16'h0C00,
                                   16'h0E01, 16'h1002, 16'h1201};

  int total = 0;
  int bad = 0;
  int frameCount = 0;
  int highCnt = 0;
  int lowCnt = 0;
  bit prevStart = 1'b0;
  bit completed = 1'b0;
  bit gapArmed = 1'b0;
  int startFrames;

  i2c_config_seq dut (
    .clock_i2c (clock_i2c),
    .rst       (rst),
    .go        (go),
    .i2c_start (i2c_start),
    .i2c_data  (i2c_data),
    .tr_end    (tr_end),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .reg_index (reg_index)
  );

  // 10 kHz I2C bit clock, scaled to a 10-unit period.
  initial begin
    clock_i2c = 1'b0;
    forever #5 clock_i2c = ~clock_i2c;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushFrame(input int idx, input bit nack, input bit noEnd);
    frameT f;
    f.data  = {8'h34, regTable[idx]};
    f.nack  = nack;
    f.noEnd = noEnd;
    sbQ.push_back(f);
  endtask

  task automatic applyStimulus();
    go = 1'b1;
    @(negedge clock_i2c);
    go = 1'b0;
  endtask

  task automatic waitEnd(input int maxCycles, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock_i2c);
      n++;
    end while (!(done || error) && n < maxCycles);
    checkOutput({tag, "_finished"}, 32'(done || error), 32'd1);
  endtask

  // Write engine model: checks each new frame against the scoreboard and
  // answers with tr_end 33 cycles into the frame, or never for timeouts.
  initial begin
    tr_end = 1'b0;
    ack    = 1'b0;
    forever begin
      @(negedge clock_i2c);
      if (i2c_start === 1'b1) begin
        if (!prevStart) begin
          frameCount++;
          highCnt   = 0;
          completed = 1'b0;
          if (gapArmed) begin
            checkOutput("gap_low_cycles", 32'(lowCnt >= 3), 32'd1);
          end
          checkOutput("frame_pending", 32'(sbQ.size() > 0), 32'd1);
          if (sbQ.size() > 0) begin
            cur = sbQ.pop_front();
            checkOutput("frame_data", {8'h00, i2c_data}, {8'h00, cur.data});
          end else begin
            cur.data  = 24'h000000;
            cur.nack  = 1'b0;
            cur.noEnd = 1'b0;
          end
        end
        highCnt++;
        if (!cur.noEnd && highCnt >= 33) begin
          tr_end    = 1'b1;
          ack       = cur.nack;
          completed = 1'b1;
        end
        prevStart = 1'b1;
      end else begin
        if (prevStart) begin
          if (cur.noEnd) begin
            checkOutput("timeout_len", 32'(highCnt), 32'd64);
          end
          gapArmed = completed || cur.noEnd;
          lowCnt   = 0;
        end
        lowCnt++;
        tr_end    = 1'b0;
        ack       = 1'b0;
        prevStart = 1'b0;
      end
    end
  end

  // Directed scenario sequence.
  initial begin
    int n;
    rst = 1'b1;
    go  = 1'b0;
    repeat (3) @(negedge clock_i2c);

    checkOutput("rst_start", 32'(i2c_start), 32'd0);
    checkOutput("rst_data", {8'h00, i2c_data}, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_index", 32'(reg_index), 32'd0);

    $display("[TB] nominal auto-start run with go pulse while busy");
    for (int i = 0; i < 11; i++) pushFrame(i, 1'b0, 1'b0);
    startFrames = frameCount;
    rst = 1'b0;
    repeat (100) @(negedge clock_i2c);
    checkOutput("busy_mid_run", 32'(busy), 32'd1);
    applyStimulus();
    waitEnd(2000, "nominal");
    checkOutput("nom_done", 32'(done), 32'd1);
    checkOutput("nom_error", 32'(error), 32'd0);
    checkOutput("nom_busy", 32'(busy), 32'd0);
    checkOutput("nom_index", 32'(reg_index), 32'd10);
    checkOutput("nom_frames", 32'(frameCount - startFrames), 32'd11);
    checkOutput("nom_queue_empty", 32'(sbQ.size()), 32'd0);

    $display("[TB] single NACK at index 3, restarted by go after done");
    for (int i = 0; i < 11; i++) begin
      if (i == 3) pushFrame(i, 1'b1, 1'b0);
      pushFrame(i, 1'b0, 1'b0);
    end
    startFrames = frameCount;
    applyStimulus();
    checkOutput("go_clears_done", 32'(done), 32'd0);
    checkOutput("go_sets_busy", 32'(busy), 32'd1);
    waitEnd(2000, "single_nack");
    checkOutput("sn_done", 32'(done), 32'd1);
    checkOutput("sn_error", 32'(error), 32'd0);
    checkOutput("sn_frames", 32'(frameCount - startFrames), 32'd12);
    checkOutput("sn_queue_empty", 32'(sbQ.size()), 32'd0);

    $display("[TB] persistent NACK at index 5");
    for (int i = 0; i < 5; i++) pushFrame(i, 1'b0, 1'b0);
    for (int a = 0; a < 4; a++) pushFrame(5, 1'b1, 1'b0);
    startFrames = frameCount;
    applyStimulus();
    waitEnd(2000, "persist_nack");
    checkOutput("pn_error", 32'(error), 32'd1);
    checkOutput("pn_done", 32'(done), 32'd0);
    checkOutput("pn_index", 32'(reg_index), 32'd5);
    checkOutput("pn_busy", 32'(busy), 32'd0);
    repeat (100) @(negedge clock_i2c);
    checkOutput("pn_frames", 32'(frameCount - startFrames), 32'd9);
    checkOutput("pn_start_low", 32'(i2c_start), 32'd0);
    checkOutput("pn_queue_empty", 32'(sbQ.size()), 32'd0);

    $display("[TB] missing tr_end at index 0");
    for (int a = 0; a < 4; a++) pushFrame(0, 1'b0, 1'b1);
    startFrames = frameCount;
    applyStimulus();
    waitEnd(2000, "timeout");
    checkOutput("to_error", 32'(error), 32'd1);
    checkOutput("to_done", 32'(done), 32'd0);
    checkOutput("to_index", 32'(reg_index), 32'd0);
    checkOutput("to_frames", 32'(frameCount - startFrames), 32'd4);
    checkOutput("to_queue_empty", 32'(sbQ.size()), 32'd0);

    $display("[TB] reset during the index 7 frame");
    for (int i = 0; i < 8; i++) pushFrame(i, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) pushFrame(i, 1'b0, 1'b0);
    startFrames = frameCount;
    applyStimulus();
    n = 0;
    while (!(i2c_start === 1'b1 && i2c_data === 24'h340C00 && highCnt == 20) && n < 3000) begin
      @(negedge clock_i2c);
      #1;
      n++;
    end
    checkOutput("mr_reached_idx7", 32'(n < 3000), 32'd1);
    rst = 1'b1;
    @(negedge clock_i2c);
    #1;
    checkOutput("mr_start", 32'(i2c_start), 32'd0);
    checkOutput("mr_data", {8'h00, i2c_data}, 32'd0);
    checkOutput("mr_busy", 32'(busy), 32'd0);
    checkOutput("mr_done", 32'(done), 32'd0);
    checkOutput("mr_error", 32'(error), 32'd0);
    checkOutput("mr_index", 32'(reg_index), 32'd0);
    rst = 1'b0;
    waitEnd(2000, "mid_reset");
    checkOutput("mr_final_done", 32'(done), 32'd1);
    checkOutput("mr_final_error", 32'(error), 32'd0);
    checkOutput("mr_final_index", 32'(reg_index), 32'd10);
    checkOutput("mr_frames", 32'(frameCount - startFrames), 32'd19);
    checkOutput("mr_queue_empty", 32'(sbQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
